// File: rtl/core_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : core_seq_if
// Brief    : Instruction-fetch and data-memory valid/ready handshakes between
//            the sequencer (master) and the memory side (slave).
// Revision : 1.0
// ============================================================================
interface core_seq_if #(
    parameter int DATA_LEN = 32
);
    logic                ifetch_req_valid;
    logic                ifetch_req_ready;
    logic [DATA_LEN-1:0] ifetch_addr;
    logic                ifetch_rsp_valid;
    logic [DATA_LEN-1:0] ifetch_rsp_data;
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic                mem_we;
    logic                mem_rsp_valid;

    modport master (
        output ifetch_req_valid, ifetch_addr, mem_req_valid, mem_we,
        input  ifetch_req_ready, ifetch_rsp_valid, ifetch_rsp_data,
               mem_req_ready, mem_rsp_valid
    );

    modport slave (
        input  ifetch_req_valid, ifetch_addr, mem_req_valid, mem_we,
        output ifetch_req_ready, ifetch_rsp_valid, ifetch_rsp_data,
               mem_req_ready, mem_rsp_valid
    );
endinterface
`default_nettype wire

// File: rtl/core_seq_fsm.sv
`default_nettype none
// ============================================================================
// Module   : core_seq_fsm
// Brief    : Multi-cycle fetch/exec/mem/writeback sequencer with reset
//            synchroniser, PC register and handshake timeouts.
//            Optional perf counters under macro CORE_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
module core_seq_fsm #(
    parameter int                  DATA_LEN        = 32,
    parameter int                  RST_SYNC_STAGES = 2,
    parameter logic [DATA_LEN-1:0] RESET_PC        = 32'h8000_0000,
    parameter int                  TIMEOUT_CYCLES  = 255
) (
    input  wire logic                sys_clk,
    input  wire logic                sys_rst_n,
    core_seq_if.master               bus,
    output logic      [DATA_LEN-1:0] inst_out,
    output logic      [DATA_LEN-1:0] pc_out,
    output logic                     inst_valid,
    input  wire logic                is_load,
    input  wire logic                is_store,
    input  wire logic                jump_flag,
    input  wire logic [DATA_LEN-1:0] jump_pc,
    input  wire logic                ebreak,
    input  wire logic                dest_wen_in,
    output logic                     reg_wen,
    output logic                     halted,
    output logic      [1:0]          err_code,
    output logic      [63:0]         cycle_cnt,
    output logic      [63:0]         instret_cnt
);

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT_I  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_MEM_REQ = 3'd4,
        ST_MEM_RSP = 3'd5,
        ST_WB      = 3'd6,
        ST_HALT    = 3'd7
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [RST_SYNC_STAGES-1:0] rst_sync;
    logic                       rst_n;
    state_t                     state, state_nxt;
    logic [DATA_LEN-1:0]        pc, pc_nxt;
    logic [1:0]                 err_nxt;
    logic [15:0]                wait_cnt;
    logic                       wait_expired, waiting, latch_inst, misaligned;
    logic                       fetch_req, data_req, data_we;

    // Asynchronous assert, synchronous release
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) rst_sync <= '0;
        else            rst_sync <= {rst_sync[RST_SYNC_STAGES-2:0], 1'b1};
    end
    assign rst_n = rst_sync[RST_SYNC_STAGES-1];

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RESET;
        else        state <= state_nxt;
    end

    assign wait_expired = (wait_cnt == TIMEOUT_LAST);
    assign misaligned   = jump_flag && (jump_pc[1:0] != 2'b00);

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        err_nxt    = err_code;
        latch_inst = 1'b0;
        fetch_req  = 1'b0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        inst_valid = 1'b0;
        reg_wen    = 1'b0;
        case (state)
            ST_RESET: state_nxt = ST_FETCH;
            ST_FETCH: begin
                fetch_req = 1'b1;
                if (bus.ifetch_req_ready) state_nxt = ST_WAIT_I;
                else if (wait_expired) begin
                    state_nxt = ST_HALT;
                    err_nxt   = 2'd1;
                end
            end
            ST_WAIT_I: begin
                if (bus.ifetch_rsp_valid) begin
                    latch_inst = 1'b1;
                    state_nxt  = ST_EXEC;
                end else if (wait_expired) begin
                    state_nxt = ST_HALT;
                    err_nxt   = 2'd1;
                end
            end
            ST_EXEC: begin
                inst_valid = 1'b1;
                if (ebreak)                  state_nxt = ST_HALT;
                else if (is_load || is_store) state_nxt = ST_MEM_REQ;
                else                         state_nxt = ST_WB;
            end
            ST_MEM_REQ: begin
                data_req = 1'b1;
                data_we  = is_store;
                if (bus.mem_req_ready) state_nxt = ST_MEM_RSP;
                else if (wait_expired) begin
                    state_nxt = ST_HALT;
                    err_nxt   = 2'd2;
                end
            end
            ST_MEM_RSP: begin
                if (bus.mem_rsp_valid) state_nxt = ST_WB;
                else if (wait_expired) begin
                    state_nxt = ST_HALT;
                    err_nxt   = 2'd2;
                end
            end
            ST_WB: begin
                // A misaligned target aborts retirement: no write, PC frozen
                if (misaligned) begin
                    state_nxt = ST_HALT;
                    err_nxt   = 2'd3;
                end else begin
                    reg_wen   = dest_wen_in;
                    pc_nxt    = jump_flag ? jump_pc : pc + DATA_LEN'(4);
                    state_nxt = ST_FETCH;
                end
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_HALT;
        endcase
    end

    assign waiting = (state == ST_FETCH) || (state == ST_WAIT_I) ||
                     (state == ST_MEM_REQ) || (state == ST_MEM_RSP);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            inst_out <= '0;
            err_code <= 2'd0;
            wait_cnt <= 16'd0;
        end else begin
            pc       <= pc_nxt;
            err_code <= err_nxt;
            if (latch_inst) inst_out <= bus.ifetch_rsp_data;
            if (state_nxt != state) wait_cnt <= 16'd0;
            else if (waiting)       wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign pc_out               = pc;
    assign halted               = (state == ST_HALT);
    assign bus.ifetch_req_valid = fetch_req;
    assign bus.ifetch_addr      = pc;
    assign bus.mem_req_valid    = data_req;
    assign bus.mem_we           = data_we;

`ifdef CORE_PERF_CNT_EN
    logic        retire;
    logic [63:0] cycle_q, instret_q;

    // ebreak counts as retired even though it never reaches writeback
    assign retire = ((state == ST_WB) && !misaligned) || ((state == ST_EXEC) && ebreak);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= 64'd0;
            instret_q <= 64'd0;
        end else begin
            if (state != ST_HALT) cycle_q   <= cycle_q + 64'd1;
            if (retire)           instret_q <= instret_q + 64'd1;
        end
    end
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = 64'd0;
    assign instret_cnt = 64'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_seq_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_seq_fsm
// Brief    : Reactive memory/decode driver with a phase-level model of the
//            sequencer; covers latency, stalls, jumps, timeouts and counters.
// Revision : 1.0
// ============================================================================
module tb_core_seq_fsm;

    localparam int          TO       = 8;
    localparam logic [31:0] RST_PC   = 32'h8000_0000;
    localparam int          BUDGET   = 200;
    localparam int          K_ALU    = 0;
    localparam int          K_LOAD   = 1;
    localparam int          K_STORE  = 2;
    localparam int          K_EBREAK = 3;
    localparam int          P_FETCH  = 0;
    localparam int          P_WAITI  = 1;
    localparam int          P_EXEC   = 2;
    localparam int          P_MREQ   = 3;
    localparam int          P_MRSP   = 4;
    localparam int          P_WB     = 5;
    localparam int          P_DONE   = 6;
    localparam int          P_HALT   = 7;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [31:0] inst_out, pc_out, jump_pc;
    logic        inst_valid, is_load, is_store, jump_flag, ebreak, dest_wen_in;
    logic        reg_wen, halted;
    logic [1:0]  err_code;
    logic [63:0] cycle_cnt, instret_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;
    logic [63:0] m_cycles, m_instret;

    core_seq_if #(.DATA_LEN(32)) bus ();

    core_seq_fsm #(
        .DATA_LEN       (32),
        .RST_SYNC_STAGES(2),
        .RESET_PC       (RST_PC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .bus        (bus),
        .inst_out   (inst_out),
        .pc_out     (pc_out),
        .inst_valid (inst_valid),
        .is_load    (is_load),
        .is_store   (is_store),
        .jump_flag  (jump_flag),
        .jump_pc    (jump_pc),
        .ebreak     (ebreak),
        .dest_wen_in(dest_wen_in),
        .reg_wen    (reg_wen),
        .halted     (halted),
        .err_code   (err_code),
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {bus.ifetch_req_valid, inst_valid, bus.mem_req_valid, reg_wen, halted};
    endfunction

    task automatic chk_counters();
`ifdef CORE_PERF_CNT_EN
        chk("cycle_cnt", cycle_cnt, m_cycles);
        chk("instret_cnt", instret_cnt, m_instret);
`else
        chk("cycle_cnt", cycle_cnt, 64'd0);
        chk("instret_cnt", instret_cnt, 64'd0);
`endif
    endtask

    task automatic idle_inputs();
        bus.ifetch_req_ready = 1'b0;
        bus.ifetch_rsp_valid = 1'b0;
        bus.ifetch_rsp_data  = 32'd0;
        bus.mem_req_ready    = 1'b0;
        bus.mem_rsp_valid    = 1'b0;
        is_load = 1'b0; is_store = 1'b0; jump_flag = 1'b0;
        jump_pc = 32'd0; ebreak = 1'b0; dest_wen_in = 1'b0;
    endtask

    // Ends positioned just after the negedge of the first FETCH cycle
    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("rst_pc", pc_out, RST_PC);
        chk("rst_inst", inst_out, 32'd0);
        chk("rst_strobes", strobes(), 5'b0);
        chk("rst_err", err_code, 2'd0);
        chk("rst_cycle", cycle_cnt, 64'd0);
        chk("rst_instret", instret_cnt, 64'd0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) begin
            @(negedge sys_clk);
            #1 chk("sync_release", strobes(), 5'b0);
        end
        @(negedge sys_clk);
        #1;
        m_pc      = RST_PC;
        m_cycles  = 64'd1;
        m_instret = 64'd0;
    endtask

    // Plays memory and decode for one instruction, checking every cycle
    task automatic run_instr(input int kind, input int f_dly, input int r_dly,
                             input int m_dly, input int mr_dly, input logic dwen,
                             input logic jflag, input logic [31:0] jpc);
        logic [31:0] inst;
        logic [4:0]  exp_v;
        logic [1:0]  exp_err;
        logic        mis;
        int          ph, ph_n, w, n;
        inst        = $urandom;
        mis         = jflag && (jpc[1:0] != 2'b00);
        is_load     = (kind == K_LOAD);
        is_store    = (kind == K_STORE);
        ebreak      = (kind == K_EBREAK);
        dest_wen_in = dwen;
        jump_flag   = jflag;
        jump_pc     = jpc;
        ph = P_FETCH; w = 0; n = 0; exp_err = 2'd0;
        while (ph < P_DONE && n < BUDGET) begin
            bus.ifetch_req_ready = 1'b0;
            bus.ifetch_rsp_valid = 1'b0;
            bus.ifetch_rsp_data  = $urandom;
            bus.mem_req_ready    = 1'b0;
            bus.mem_rsp_valid    = 1'b0;
            ph_n  = ph;
            exp_v = 5'b00000;
            case (ph)
                P_FETCH: begin
                    exp_v = 5'b10000;
                    bus.ifetch_rsp_valid = 1'($urandom_range(0, 1));
                    if (w >= f_dly) begin bus.ifetch_req_ready = 1'b1; ph_n = P_WAITI; end
                    else if (w == TO - 1) begin ph_n = P_HALT; exp_err = 2'd1; end
                end
                P_WAITI: begin
                    if (w >= r_dly) begin
                        bus.ifetch_rsp_valid = 1'b1;
                        bus.ifetch_rsp_data  = inst;
                        ph_n = P_EXEC;
                    end else if (w == TO - 1) begin ph_n = P_HALT; exp_err = 2'd1; end
                end
                P_EXEC: begin
                    exp_v = 5'b01000;
                    if (kind == K_EBREAK) begin ph_n = P_HALT; m_instret++; end
                    else if (kind == K_LOAD || kind == K_STORE) ph_n = P_MREQ;
                    else ph_n = P_WB;
                end
                P_MREQ: begin
                    exp_v = 5'b00100;
                    if (w >= m_dly) begin bus.mem_req_ready = 1'b1; ph_n = P_MRSP; end
                    else if (w == TO - 1) begin ph_n = P_HALT; exp_err = 2'd2; end
                end
                P_MRSP: begin
                    if (w >= mr_dly) begin bus.mem_rsp_valid = 1'b1; ph_n = P_WB; end
                    else if (w == TO - 1) begin ph_n = P_HALT; exp_err = 2'd2; end
                end
                default: begin
                    exp_v = {3'b000, dwen && !mis, 1'b0};
                    if (mis) begin ph_n = P_HALT; exp_err = 2'd3; end
                    else begin
                        m_pc = jflag ? jpc : m_pc + 32'd4;
                        m_instret++;
                        ph_n = P_DONE;
                    end
                end
            endcase
            #1;
            chk("strobes", strobes(), exp_v);
            if (ph == P_FETCH) chk("ifetch_addr", bus.ifetch_addr, m_pc);
            if (ph == P_EXEC)  chk("inst_out", inst_out, inst);
            if (ph == P_MREQ)  chk("mem_we", bus.mem_we, is_store);
            w  = (ph_n == ph) ? w + 1 : 0;
            ph = ph_n;
            n++;
            m_cycles++;
            @(negedge sys_clk);
        end
        #1;
        chk("cycle_budget", 64'(ph >= P_DONE), 64'd1);
        if (ph == P_HALT) begin
            chk("halted", {bus.ifetch_req_valid, halted}, 2'b01);
            chk("err_code", err_code, exp_err);
        end else begin
            chk("next_fetch", {bus.ifetch_req_valid, halted}, 2'b10);
            chk("next_addr", bus.ifetch_addr, m_pc);
            chk("err_code", err_code, 2'd0);
        end
        chk("pc_out", pc_out, m_pc);
        chk_counters();
    endtask

    task automatic check_frozen();
        repeat (5) @(negedge sys_clk);
        #1;
        chk("halt_strobes", strobes(), 5'b00001);
        chk("halt_pc", pc_out, m_pc);
        chk_counters();
    endtask

    initial begin
        int          kind;
        logic        dwen, jflag;
        logic [31:0] jpc;
        idle_inputs();
        do_reset();

        // Back-to-back handshakes, then a 5-cycle fetch stall and a slow store
        run_instr(K_ALU, 0, 0, 0, 0, 1'b1, 1'b0, 32'd0);
        run_instr(K_ALU, 5, 0, 0, 0, 1'b1, 1'b0, 32'd0);
        run_instr(K_STORE, 0, 0, 3, 0, 1'b0, 1'b0, 32'd0);
        run_instr(K_LOAD, 1, 2, 0, 1, 1'b1, 1'b0, 32'd0);
        run_instr(K_ALU, 0, 0, 0, 0, 1'b1, 1'b1, 32'h8000_0100);

        for (int i = 0; i < 24; i++) begin
            kind  = int'($urandom_range(0, 2));
            dwen  = (kind == K_STORE) ? 1'b0 : 1'($urandom_range(0, 1));
            jflag = ($urandom_range(0, 3) == 0);
            jpc   = m_pc + {22'd0, 8'($urandom), 2'b00};
            run_instr(kind, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), dwen, jflag, jpc);
        end

        run_instr(K_ALU, 0, 0, 0, 0, 1'b1, 1'b1, 32'h8000_0102);
        check_frozen();

        do_reset();
        run_instr(K_ALU, 0, 1000, 0, 0, 1'b1, 1'b0, 32'd0);
        check_frozen();

        do_reset();
        run_instr(K_LOAD, 0, 0, 0, 1000, 1'b1, 1'b0, 32'd0);
        check_frozen();

        // Reset while waiting on an instruction response
        do_reset();
        run_instr(K_ALU, 0, 0, 0, 0, 1'b1, 1'b0, 32'd0);
        run_instr(K_ALU, 0, 0, 0, 0, 1'b0, 1'b0, 32'd0);
        bus.ifetch_req_ready = 1'b1;
        @(negedge sys_clk);
        bus.ifetch_req_ready = 1'b0;
        #1 chk("wait_i_idle", strobes(), 5'b0);
        do_reset();

        for (int i = 0; i < 10; i++)
            run_instr(K_ALU, 0, 0, 0, 0, 1'b1, 1'b0, 32'd0);
        run_instr(K_EBREAK, 0, 0, 0, 0, 1'b0, 1'b0, 32'd0);
`ifdef CORE_PERF_CNT_EN
        chk("instret_11", instret_cnt, 64'd11);
`endif
        check_frozen();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
